inst_sequencer: RTL and testbench



---
 rtl/inst_sequencer.sv | 133 +++++++++++++
 tb/tb_inst_sequencer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_sequencer.sv
// Multi-cycle FETCH/EXEC/MEM/WB sequencer for the hxd32 core.
// It qualifies the decoder write enables so each instruction commits exactly once.
module inst_sequencer #(
   parameter int XLEN      = 32,
   parameter int TIMEOUT_W = 4
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            halt_i,
   output logic            iram_req_o,
   input  logic            iram_ack_i,
   input  logic [XLEN-1:0] iram_data_i,
   output logic [XLEN-1:0] inst_data_o,
   input  logic            dec_pc_wr_en_i,
   input  logic            dec_rd_wr_en_i,
   input  logic            dec_dram_wr_en_i,
   output logic            dram_req_o,
   input  logic            dram_ack_i,
   output logic            pc_wr_en_o,
   output logic            rd_wr_en_o,
   output logic            dram_wr_en_o,
   output logic            halted_o,
   output logic            bus_err_o,
   output logic [XLEN-1:0] instret_o
);

   typedef enum logic [2:0] {
      S_FETCH = 3'd0,
      S_EXEC  = 3'd1,
      S_MEM   = 3'd2,
      S_WB    = 3'd3,
      S_HALT  = 3'd4
   } state_t;

   localparam logic [TIMEOUT_W-1:0] WD_MAX = '1;

   state_t                r_state;
   state_t                w_next;
   logic [XLEN-1:0]       r_ir;
   logic [XLEN-1:0]       r_instret;
   logic [TIMEOUT_W-1:0]  r_wd;
   logic                  r_bus_err;

   logic [TIMEOUT_W-1:0]  w_wd_inc;
   logic                  w_wd_expire;
   logic                  w_is_mem;
   logic                  w_iram_req;
   logic                  w_dram_req;
   logic                  w_dram_wr;
   logic                  w_pc_wr;
   logic                  w_rd_wr;
   logic                  w_commit;
   logic                  w_timeout;

   assign w_is_mem    = (r_ir[6:2] == 5'b00000) || (r_ir[6:2] == 5'b01000);
   assign w_wd_inc    = r_wd + 1'b1;
   // Abort on the wait cycle that would bring the counter to all-ones.
   assign w_wd_expire = (w_wd_inc == WD_MAX);

   always_comb begin
      w_next     = r_state;
      w_iram_req = 1'b0;
      w_dram_req = 1'b0;
      w_dram_wr  = 1'b0;
      w_pc_wr    = 1'b0;
      w_rd_wr    = 1'b0;
      w_commit   = 1'b0;
      w_timeout  = 1'b0;
      case (r_state)
         S_FETCH: begin
            w_iram_req = 1'b1;
            if (iram_ack_i) begin
               w_next = S_EXEC;
            end else if (w_wd_expire) begin
               w_timeout = 1'b1;
               w_next    = S_HALT;
            end
         end
         S_EXEC: begin
            if (w_is_mem) w_next = S_MEM;
            else          w_commit = 1'b1;
         end
         S_MEM: begin
            w_dram_req = 1'b1;
            w_dram_wr  = dec_dram_wr_en_i;
            if (dram_ack_i) begin
               w_next = S_WB;
            end else if (w_wd_expire) begin
               w_timeout = 1'b1;
               w_next    = S_HALT;
            end
         end
         S_WB:    w_commit = 1'b1;
         S_HALT:  if (!halt_i) w_next = S_FETCH;
         default: w_next = S_FETCH;
      endcase
      // Commit cycle: the only place halt_i is sampled outside HALT.
      if (w_commit) begin
         w_pc_wr = dec_pc_wr_en_i;
         w_rd_wr = dec_rd_wr_en_i;
         w_next  = halt_i ? S_HALT : S_FETCH;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state   <= S_FETCH;
         r_ir      <= '0;
         r_instret <= '0;
         r_wd      <= '0;
         r_bus_err <= 1'b0;
      end else begin
         r_state <= w_next;
         if (r_state == S_FETCH && iram_ack_i) r_ir <= iram_data_i;
         if (w_commit)  r_instret <= r_instret + 1'b1;
         if (w_timeout) r_bus_err <= 1'b1;
         if (w_next != r_state)            r_wd <= '0;
         else if (w_iram_req || w_dram_req) r_wd <= w_wd_inc;
      end
   end

   // Gate combinational outputs so they read as reset values while rst_i is high.
   assign iram_req_o   = w_iram_req & ~rst_i;
   assign dram_req_o   = w_dram_req & ~rst_i;
   assign dram_wr_en_o = w_dram_wr  & ~rst_i;
   assign pc_wr_en_o   = w_pc_wr    & ~rst_i;
   assign rd_wr_en_o   = w_rd_wr    & ~rst_i;
   assign halted_o     = (r_state == S_HALT);
   assign bus_err_o    = r_bus_err;
   assign instret_o    = r_instret;
   assign inst_data_o  = r_ir;

endmodule

// File: tb/tb_inst_sequencer.sv
// Randomized bench for inst_sequencer: expected per-cycle outputs are built from
// the instruction-level timing rules (fetch waits, exec, mem waits, commit, halt).
module tb_inst_sequencer;
   localparam int XLEN = 32;
   localparam int TW   = 4;
   localparam logic [31:0] ADDI = 32'h00500093;
   localparam logic [31:0] LW   = 32'h00002103;
   localparam logic [31:0] SW   = 32'h00202223;

   logic        clk = 1'b0;
   logic        rst, halt, iack, dack, dpc, drd, dst;
   logic [31:0] idata, ir, instret;
   logic        ireq, dreq, pcw, rdw, dwr, halted, berr;

   int          total = 0;
   int          bad   = 0;
   logic [31:0] m_instret = '0;
   logic        m_berr    = 1'b0;

   always #5 clk = ~clk;

   inst_sequencer #(.XLEN(XLEN), .TIMEOUT_W(TW)) dut (
      .clk_i(clk), .rst_i(rst), .halt_i(halt),
      .iram_req_o(ireq), .iram_ack_i(iack), .iram_data_i(idata),
      .inst_data_o(ir),
      .dec_pc_wr_en_i(dpc), .dec_rd_wr_en_i(drd), .dec_dram_wr_en_i(dst),
      .dram_req_o(dreq), .dram_ack_i(dack),
      .pc_wr_en_o(pcw), .rd_wr_en_o(rdw), .dram_wr_en_o(dwr),
      .halted_o(halted), .bus_err_o(berr), .instret_o(instret)
   );

   // {iram_req, dram_req, dram_wr, pc_wr, rd_wr, halted, bus_err}
   function automatic logic [6:0] outs();
      return {ireq, dreq, dwr, pcw, rdw, halted, berr};
   endfunction

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic rnd_in();
      iack  = 1'($urandom);
      dack  = 1'($urandom);
      dpc   = 1'($urandom);
      drd   = 1'($urandom);
      dst   = 1'($urandom);
      halt  = 1'($urandom);
      idata = $urandom;
   endtask

   task automatic apply_dec(input bit fixdec, input bit fpc, input bit frd, input bit fst);
      if (fixdec) begin
         dpc = fpc; drd = frd; dst = fst;
      end
   endtask

   // Drives one instruction from the FETCH state through commit (and optional halt).
   task automatic exec_inst(input logic [31:0] inst, input int fw, input int mw,
                            input bit do_halt, input int hold, input bit fixdec,
                            input bit fpc, input bit frd, input bit fst);
      logic [6:0] e;
      bit mem;
      mem = (inst[6:2] == 5'b00000) || (inst[6:2] == 5'b01000);
      for (int c = 0; c <= fw; c++) begin
         rnd_in(); apply_dec(fixdec, fpc, frd, fst);
         iack = (c == fw);
         if (c == fw) idata = inst;
         @(negedge clk);
         e = {1'b1, 5'b00000, m_berr};
         total++; if (outs() !== e) begin bad++; $display("FAIL fetch c%0d: got %b want %b", c, outs(), e); end
         step();
      end
      rnd_in(); apply_dec(fixdec, fpc, frd, fst);
      if (!mem) halt = do_halt;
      @(negedge clk);
      e = {3'b000, (mem ? 2'b00 : {dpc, drd}), 1'b0, m_berr};
      total++; if (outs() !== e) begin bad++; $display("FAIL exec: got %b want %b", outs(), e); end
      total++; if (ir !== inst) begin bad++; $display("FAIL ir: got %h want %h", ir, inst); end
      step();
      if (mem) begin
         for (int c = 0; c <= mw; c++) begin
            rnd_in(); apply_dec(fixdec, fpc, frd, fst);
            dack = (c == mw);
            @(negedge clk);
            e = {2'b01, dst, 3'b000, m_berr};
            total++; if (outs() !== e) begin bad++; $display("FAIL mem c%0d: got %b want %b", c, outs(), e); end
            step();
         end
         rnd_in(); apply_dec(fixdec, fpc, frd, fst);
         halt = do_halt;
         @(negedge clk);
         e = {3'b000, dpc, drd, 1'b0, m_berr};
         total++; if (outs() !== e) begin bad++; $display("FAIL wb: got %b want %b", outs(), e); end
         step();
      end
      m_instret = m_instret + 1;
      total++; if (instret !== m_instret) begin bad++; $display("FAIL instret: got %0d want %0d", instret, m_instret); end
      if (do_halt) begin
         for (int h = 0; h <= hold; h++) begin
            rnd_in();
            halt = (h != hold);
            @(negedge clk);
            e = {5'b00000, 1'b1, m_berr};
            total++; if (outs() !== e) begin bad++; $display("FAIL halt h%0d: got %b want %b", h, outs(), e); end
            step();
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      rnd_in(); iack = 1'b1; dack = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      total++; if (outs() !== 7'b0) begin bad++; $display("FAIL reset_outs: got %b want 0", outs()); end
      total++; if (instret !== 32'd0) begin bad++; $display("FAIL reset_instret: got %0d want 0", instret); end
      total++; if (ir !== 32'd0) begin bad++; $display("FAIL reset_ir: got %h want 0", ir); end
      step();
      rst = 1'b0; m_instret = '0; m_berr = 1'b0;
   endtask

   task automatic test_alu();
      exec_inst(ADDI, 0, 0, 0, 0, 1, 1, 1, 0);
      total++; if (instret !== 32'd1) begin bad++; $display("FAIL alu_instret: got %0d want 1", instret); end
   endtask

   task automatic test_load();
      exec_inst(LW, 0, 3, 0, 0, 1, 0, 1, 0);
   endtask

   task automatic test_store();
      exec_inst(SW, 1, 0, 0, 0, 1, 1, 0, 1);
   endtask

   task automatic test_halt();
      exec_inst(ADDI, 0, 0, 1, 3, 1, 1, 1, 0);
      exec_inst(LW, 2, 1, 1, 0, 0, 0, 0, 0);
   endtask

   task automatic test_watchdog_edge();
      exec_inst(ADDI, 14, 0, 0, 0, 0, 0, 0, 0);
      exec_inst(SW, 0, 14, 0, 0, 0, 0, 0, 0);
      total++; if (berr !== 1'b0) begin bad++; $display("FAIL wd_edge_berr: got %b want 0", berr); end
   endtask

   task automatic test_random();
      logic [31:0] w;
      int          kind;
      logic [4:0]  op;
      for (int n = 0; n < 40; n++) begin
         w    = $urandom;
         kind = $urandom_range(0, 2);
         if (kind == 0) begin
            op = 5'($urandom_range(1, 31));
            if (op == 5'b01000) op = 5'b01001;
            w[6:2] = op;
         end else begin
            w[6:2] = (kind == 1) ? 5'b00000 : 5'b01000;
         end
         exec_inst(w, $urandom_range(0, 4), $urandom_range(0, 4),
                   ($urandom_range(0, 4) == 0), $urandom_range(0, 2), 0, 0, 0, 0);
      end
   endtask

   task automatic test_timeout();
      logic [6:0] e;
      for (int c = 0; c < 15; c++) begin
         rnd_in(); iack = 1'b0;
         @(negedge clk);
         e = 7'b1000000;
         total++; if (outs() !== e) begin bad++; $display("FAIL to_fetch c%0d: got %b want %b", c, outs(), e); end
         step();
      end
      m_berr = 1'b1;
      rnd_in(); halt = 1'b1;
      @(negedge clk);
      total++; if (outs() !== 7'b0000011) begin bad++; $display("FAIL to_halt: got %b want 0000011", outs()); end
      total++; if (instret !== m_instret) begin bad++; $display("FAIL to_instret: got %0d want %0d", instret, m_instret); end
      step();
      rnd_in(); halt = 1'b0;
      @(negedge clk);
      total++; if (outs() !== 7'b0000011) begin bad++; $display("FAIL to_release: got %b want 0000011", outs()); end
      step();
      // Now a data-side timeout on a load.
      rnd_in(); iack = 1'b1; idata = LW;
      @(negedge clk);
      total++; if (outs() !== 7'b1000001) begin bad++; $display("FAIL tom_fetch: got %b want 1000001", outs()); end
      step();
      rnd_in();
      @(negedge clk);
      total++; if (outs() !== 7'b0000001) begin bad++; $display("FAIL tom_exec: got %b want 0000001", outs()); end
      step();
      for (int c = 0; c < 15; c++) begin
         rnd_in(); dack = 1'b0;
         @(negedge clk);
         e = {2'b01, dst, 4'b0001};
         total++; if (outs() !== e) begin bad++; $display("FAIL tom_mem c%0d: got %b want %b", c, outs(), e); end
         step();
      end
      rnd_in(); halt = 1'b0;
      @(negedge clk);
      total++; if (outs() !== 7'b0000011) begin bad++; $display("FAIL tom_halt: got %b want 0000011", outs()); end
      total++; if (instret !== m_instret) begin bad++; $display("FAIL tom_instret: got %0d want %0d", instret, m_instret); end
      step();
      exec_inst(ADDI, 1, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic test_reset_mid();
      rnd_in(); iack = 1'b1; idata = LW;
      step();
      rnd_in();
      step();
      for (int c = 0; c < 2; c++) begin
         rnd_in(); dack = 1'b0; dst = 1'b1;
         @(negedge clk);
         total++; if (dreq !== 1'b1) begin bad++; $display("FAIL rm_dreq c%0d: got %b want 1", c, dreq); end
         step();
      end
      rnd_in(); dack = 1'b0; dst = 1'b1;
      #2 rst = 1'b1;
      #1;
      total++; if (outs() !== 7'b0) begin bad++; $display("FAIL rm_outs: got %b want 0", outs()); end
      total++; if (instret !== 32'd0) begin bad++; $display("FAIL rm_instret: got %0d want 0", instret); end
      total++; if (ir !== 32'd0) begin bad++; $display("FAIL rm_ir: got %h want 0", ir); end
      step();
      rst = 1'b0; m_instret = '0; m_berr = 1'b0;
      exec_inst(ADDI, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      rst = 1'b1; halt = 1'b0; iack = 1'b0; dack = 1'b0;
      dpc = 1'b0; drd = 1'b0; dst = 1'b0; idata = '0;
      test_reset();
      test_alu();
      test_load();
      test_store();
      test_halt();
      test_watchdog_edge();
      test_random();
      test_timeout();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
